conv_seq_ctrl: RTL and testbench
================================

// Module: conv_seq_ctrl
// PURPOSE
//   Sequencer for the ml_acc_system convolution datapath. Sits behind the S00 AXI-lite register file.
//   A start pulse from reg10 triggers the run: weights and inputs are read from the Weight/Input BRAMs,
//   a signed 32x32 multiply-accumulate runs over KERNEL_LEN taps per window, and the saturated result
//   goes to the OUTACT BRAM. Busy/done status is reported back to reg0.
// PARAMETERS
//   KERNEL_LEN   25             taps per output window (>=1)
//   DATA_W       32             BRAM word / operand width
//   ADDR_W       16             BRAM byte-address width (word k at byte k*4)
//   ACC_W        72             accumulator width (>= 2*DATA_W + clog2(KERNEL_LEN))
//   BRAM_RD_LAT  1              BRAM read latency in cycles (1 or 2)
//   DONE_MAGIC   32'hD00D1234   status word presented while done
// PORTS
//   s00_axi_aclk     in   1        clock
//   s00_axi_aresetn  in   1        reset, asynchronous, active-low
//   start_reg        in   1        reg10 bit0; the rising edge starts a run
//   clr_done         in   1        one-cycle pulse that clears done
//   cfg_n_out        in   8        output windows per run; sampled at start
//   cfg_stride       in   8        input advance per window, in words; sampled at start
//   w_addr/w_en      out  ADDR_W/1 Weight BRAM read port
//   w_dout           in   DATA_W   Weight BRAM read data
//   x_addr/x_en      out  ADDR_W/1 Input BRAM read port
//   x_dout           in   DATA_W   Input BRAM read data
//   o_addr/o_we      out  ADDR_W/4 OUTACT BRAM write port (o_we = 4'hF or 0)
//   o_din            out  DATA_W   OUTACT write data
//   busy             out  1        run in progress
//   done             out  1        sticky; the last run completed
//   status_o         out  32       done ? DONE_MAGIC : {31'b0,busy}
// BEHAVIOUR
//   Reset: all outputs 0, FSM = IDLE, accumulator and counters 0. Asserting reset mid-run aborts the run
//     immediately. No further BRAM write occurs, and done stays 0.
//   Start detect: start_d is a register of start_reg; start edge = start_reg & ~start_d.
//     - An edge in IDLE or DONE latches cfg_n_out and cfg_stride, clears done, and enters FETCH on the next cycle.
//     - An edge while busy is ignored.
//     - A level held high gives exactly one run.
//   cfg_n_out == 0: go IDLE -> DONE directly with zero writes.
//   FSM: IDLE -> FETCH -> DRAIN -> WRITE -> (FETCH | DONE); DONE -> FETCH on a new start edge.
//   FETCH (KERNEL_LEN cycles), tap j = 0..KERNEL_LEN-1:
//     - w_en = x_en = 1
//     - w_addr = j*4
//     - x_addr = (k*cfg_stride + j)*4, where k = window index
//   DRAIN (BRAM_RD_LAT cycles): no new reads issued; remaining read data returns.
//   MAC: a valid shift register of depth BRAM_RD_LAT tracks the issued reads.
//     - On each valid return: acc += $signed(w_dout) * $signed(x_dout), sign-extended to ACC_W.
//     - acc clears on entry to FETCH.
//   WRITE (1 cycle):
//     - o_we = 4'hF, o_addr = k*4
//     - o_din = acc saturated to the signed DATA_W range (clip to 0x7FFFFFFF / 0x80000000)
//     - k increments; if k == n_out-1, go to DONE, else go to FETCH.
//   Throughput: exactly KERNEL_LEN + BRAM_RD_LAT + 1 cycles per window.
//   busy = 1 in FETCH, DRAIN and WRITE.
//   DONE state: done = 1, busy = 0. done clears on clr_done or a new start edge.
//   Simultaneous start edge and clr_done in DONE: the start takes effect and done = 0.
//   Address arithmetic wraps modulo 2^ADDR_W and is not flagged.
//   All enables are deasserted outside FETCH and WRITE.
// STRUCTURE
//   Shared package ml_acc_pkg:
//     - FSM state typedef (IDLE, FETCH, DRAIN, WRITE, DONE)
//     - DONE_MAGIC
//     - BRAM base constants: INPUT 0x40000000, WEIGHT 0x42000000, OUTACT 0x44000000, REGS 0x43C00000
//   One sub-module, conv_mac_unit: signed multiply, accumulate, clear, and saturate-to-DATA_W.
//   The controller holds the FSM, counters, address generation and the valid pipeline.
// TESTING
//   1. Weights all 1, inputs x[i]=i, n_out=1: pulse reg10 -> OUTACT[0] = 300;
//      done after 25+1+1 cycles; status_o = 0xD00D1234.
//   2. Same memories, n_out=3, stride=1 -> OUTACT[0..2] = 300, 325, 350; 81 busy cycles; one write per window.
//   3. Weights 0x7FFFFFFF, inputs 0x7FFFFFFF -> OUTACT[0] = 0x7FFFFFFF.
//      Weights 0x80000000, inputs 0x7FFFFFFF -> OUTACT[0] = 0x80000000.
//      Weights 2, inputs -3 -> 0xFFFFFF6A (-150).
//   4. Hold start_reg high for 200 ns, then low -> exactly one run. A second edge during busy -> ignored,
//      outputs unchanged. A new edge in DONE -> done drops the next cycle and the run repeats.
//   5. Deassert s00_axi_aresetn during FETCH of window 1 -> o_we never asserted afterwards, busy = done = 0,
//      status_o = 0. Release reset, start again -> correct results.
//   6. n_out=0 -> done with no OUTACT writes. clr_done in DONE -> done = 0, status_o = 0.

Source files
------------

// File: rtl/ml_acc_pkg.sv
// Shared definitions for the ml_acc_system convolution accelerator:
// sequencer state encoding, status magic word and system memory map.
package ml_acc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] DONE_MAGIC  = 32'hD00D_1234;

  localparam logic [31:0] INPUT_BASE  = 32'h4000_0000;
  localparam logic [31:0] WEIGHT_BASE = 32'h4200_0000;
  localparam logic [31:0] OUTACT_BASE = 32'h4400_0000;
  localparam logic [31:0] REGS_BASE   = 32'h43C0_0000;

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate with synchronous clear and a combinational
// saturate-to-DATA_W view of the accumulator.
module conv_mac_unit #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 72
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sat
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    r_acc;
  logic [ACC_W-DATA_W:0]      w_hi;
  logic                       w_ovf;

  assign w_prod     = $signed(i_a) * $signed(i_b);
  assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  // The value fits in DATA_W only when every bit from the DATA_W sign bit up matches.
  assign w_hi  = r_acc[ACC_W-1:DATA_W-1];
  assign w_ovf = !((&w_hi) || (~|w_hi));

  always_comb begin
    o_sat = r_acc[DATA_W-1:0];
    if (w_ovf) begin
      o_sat = r_acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: fetches KERNEL_LEN weight/input pairs per window,
// accumulates them in conv_mac_unit and writes one saturated result per window.
module conv_seq_ctrl
  import ml_acc_pkg::*;
#(
  parameter int KERNEL_LEN  = 25,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int ACC_W       = 72,
  parameter int BRAM_RD_LAT = 1
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_aresetn,
  input  logic              start_reg,
  input  logic              clr_done,
  input  logic [7:0]        cfg_n_out,
  input  logic [7:0]        cfg_stride,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_en,
  input  logic [DATA_W-1:0] w_dout,
  output logic [ADDR_W-1:0] x_addr,
  output logic              x_en,
  input  logic [DATA_W-1:0] x_dout,
  output logic [ADDR_W-1:0] o_addr,
  output logic [3:0]        o_we,
  output logic [DATA_W-1:0] o_din,
  output logic              busy,
  output logic              done,
  output logic [31:0]       status_o,
  output state_t            o_dbg_state
);

  localparam int TAP_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam int DRN_W = (BRAM_RD_LAT > 1) ? $clog2(BRAM_RD_LAT) : 1;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_start_d;
  logic                   r_done;
  logic [TAP_W-1:0]       r_tap;
  logic [DRN_W-1:0]       r_drain;
  logic [7:0]             r_k;
  logic [7:0]             r_n_out;
  logic [7:0]             r_stride;
  logic [ADDR_W-1:0]      r_base;
  logic [BRAM_RD_LAT-1:0] r_vld;

  logic                   w_start_edge;
  logic                   w_accept;
  logic                   w_tap_last;
  logic                   w_drain_last;
  logic                   w_last_win;
  logic                   w_acc_clr;
  logic [ADDR_W-1:0]      w_tap_a;
  logic [ADDR_W-1:0]      w_k_a;
  logic [DATA_W-1:0]      w_sat;

  assign w_start_edge = start_reg & ~r_start_d;
  assign w_accept     = w_start_edge && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_tap_last   = (r_tap == TAP_W'(KERNEL_LEN - 1));
  assign w_drain_last = (r_drain == DRN_W'(BRAM_RD_LAT - 1));
  assign w_last_win   = (r_k == (r_n_out - 8'd1));
  assign w_acc_clr    = (w_next == ST_FETCH) && (r_state != ST_FETCH);
  assign w_tap_a      = ADDR_W'(r_tap);
  assign w_k_a        = ADDR_W'(r_k);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_accept) w_next = (cfg_n_out == 8'd0) ? ST_DONE : ST_FETCH;
      ST_FETCH:         if (w_tap_last) w_next = ST_DRAIN;
      ST_DRAIN:         if (w_drain_last) w_next = ST_WRITE;
      ST_WRITE:         w_next = w_last_win ? ST_DONE : ST_FETCH;
      default:          w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_en   = 1'b0;
    x_en   = 1'b0;
    w_addr = '0;
    x_addr = '0;
    o_we   = 4'h0;
    o_addr = '0;
    o_din  = '0;
    case (r_state)
      ST_FETCH: begin
        w_en   = 1'b1;
        x_en   = 1'b1;
        w_addr = w_tap_a << 2;
        x_addr = (r_base + w_tap_a) << 2;
      end
      ST_WRITE: begin
        o_we   = 4'hF;
        o_addr = w_k_a << 2;
        o_din  = w_sat;
      end
      default: ;
    endcase
  end

  assign busy        = (r_state == ST_FETCH) || (r_state == ST_DRAIN) || (r_state == ST_WRITE);
  assign done        = r_done;
  assign status_o    = r_done ? DONE_MAGIC : {31'b0, busy};
  assign o_dbg_state = r_state;

  // Counters, latched configuration, sticky done and the read-valid pipeline.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_start_d <= 1'b0;
      r_done    <= 1'b0;
      r_tap     <= '0;
      r_drain   <= '0;
      r_k       <= '0;
      r_n_out   <= '0;
      r_stride  <= '0;
      r_base    <= '0;
      r_vld     <= '0;
    end else begin
      r_start_d <= start_reg;
      r_vld[0]  <= (r_state == ST_FETCH);
      for (int i = 1; i < BRAM_RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
      if (w_accept) begin
        r_n_out  <= cfg_n_out;
        r_stride <= cfg_stride;
        r_k      <= '0;
        r_base   <= '0;
        r_tap    <= '0;
        r_drain  <= '0;
      end else begin
        case (r_state)
          ST_FETCH: r_tap   <= w_tap_last ? '0 : r_tap + 1'b1;
          ST_DRAIN: r_drain <= w_drain_last ? '0 : r_drain + 1'b1;
          ST_WRITE: begin
            r_k    <= r_k + 8'd1;
            r_base <= r_base + ADDR_W'(r_stride);
          end
          default: ;
        endcase
      end
      if (w_accept) begin
        r_done <= (cfg_n_out == 8'd0);
      end else if ((r_state == ST_WRITE) && (w_next == ST_DONE)) begin
        r_done <= 1'b1;
      end else if (clr_done) begin
        r_done <= 1'b0;
      end
    end
  end

  conv_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .i_clr (w_acc_clr),
    .i_en  (r_vld[BRAM_RD_LAT-1]),
    .i_a   (w_dout),
    .i_b   (x_dout),
    .o_sat (w_sat)
  );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl with behavioural 1-cycle BRAMs and an
// OUTACT write scoreboard fed by hand-computed expected {addr, data} pairs.
module tb_conv_seq_ctrl;
  import ml_acc_pkg::*;

  localparam int K  = 25;
  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk;
  logic          rst_n;
  logic          start_reg;
  logic          clr_done;
  logic [7:0]    cfg_n_out;
  logic [7:0]    cfg_stride;
  logic [AW-1:0] w_addr;
  logic          w_en;
  logic [DW-1:0] w_dout;
  logic [AW-1:0] x_addr;
  logic          x_en;
  logic [DW-1:0] x_dout;
  logic [AW-1:0] o_addr;
  logic [3:0]    o_we;
  logic [DW-1:0] o_din;
  logic          busy;
  logic          done;
  logic [31:0]   status_o;
  state_t        dbg_state;

  logic [DW-1:0]    wmem [0:63];
  logic [DW-1:0]    xmem [0:63];
  logic [AW+DW-1:0] exp_q [$];

  int tests_run = 0;
  int fails     = 0;
  int wr_count  = 0;
  int busy_cnt  = 0;
  int b0, w0, cyc;

  conv_seq_ctrl #(
    .KERNEL_LEN (K),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .ACC_W      (72),
    .BRAM_RD_LAT(1)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .start_reg       (start_reg),
    .clr_done        (clr_done),
    .cfg_n_out       (cfg_n_out),
    .cfg_stride      (cfg_stride),
    .w_addr          (w_addr),
    .w_en            (w_en),
    .w_dout          (w_dout),
    .x_addr          (x_addr),
    .x_en            (x_en),
    .x_dout          (x_dout),
    .o_addr          (o_addr),
    .o_we            (o_we),
    .o_din           (o_din),
    .busy            (busy),
    .done            (done),
    .status_o        (status_o),
    .o_dbg_state     (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // BRAM models, one-cycle read latency
  always @(posedge clk) begin
    if (w_en) w_dout <= wmem[w_addr[7:2]];
    if (x_en) x_dout <= xmem[x_addr[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every OUTACT write must match the head of exp_q
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (rst_n && (o_we != 4'h0)) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {28'h0, o_we}, 32'h0);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("o_we", {28'h0, o_we}, 32'hF);
        check("o_addr", {16'h0, o_addr}, {16'h0, e[AW+DW-1:DW]});
        check("o_din", o_din, e[DW-1:0]);
      end
    end
  end

  task automatic fill_mem(input logic [DW-1:0] wv, input logic [DW-1:0] xv, input bit x_ramp);
    for (int i = 0; i < 64; i++) begin
      wmem[i] = wv;
      xmem[i] = x_ramp ? DW'(i) : xv;
    end
  endtask

  task automatic pulse_start(input logic [7:0] n, input logic [7:0] s);
    cfg_n_out  = n;
    cfg_stride = s;
    start_reg  = 1'b1;
    @(negedge clk);
    start_reg  = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int c;
    c = 0;
    while (!done && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check("done_timeout", {31'h0, done}, 32'h1);
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    rst_n = 1'b0; start_reg = 1'b0; clr_done = 1'b0;
    cfg_n_out = 8'd0; cfg_stride = 8'd0;
    fill_mem(32'd1, 32'd0, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_status", status_o, 32'h0);
    check("rst_we", {28'h0, o_we}, 32'h0);
    check("rst_en", {30'h0, w_en, x_en}, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single window, sum of 0..24
    push_exp(16'h0, 32'd300);
    b0 = busy_cnt; w0 = wr_count;
    pulse_start(8'd1, 8'd1);
    wait_done(100);
    check("t1_status", status_o, 32'hD00D1234);
    check("t1_busy_cycles", 32'(busy_cnt - b0), 32'd27);
    check("t1_writes", 32'(wr_count - w0), 32'd1);
    check("t1_state", 32'(dbg_state), 32'(ST_DONE));

    // 2: three windows, stride 1
    push_exp(16'h0, 32'd300); push_exp(16'h4, 32'd325); push_exp(16'h8, 32'd350);
    b0 = busy_cnt; w0 = wr_count;
    pulse_start(8'd3, 8'd1);
    check("t2_done_cleared", {31'h0, done}, 32'h0);
    wait_done(200);
    check("t2_busy_cycles", 32'(busy_cnt - b0), 32'd81);
    check("t2_writes", 32'(wr_count - w0), 32'd3);

    // 3: saturation and signed arithmetic
    fill_mem(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
    push_exp(16'h0, 32'h7FFFFFFF);
    pulse_start(8'd1, 8'd0);
    wait_done(100);
    fill_mem(32'h80000000, 32'h7FFFFFFF, 1'b0);
    push_exp(16'h0, 32'h80000000);
    pulse_start(8'd1, 8'd0);
    wait_done(100);
    fill_mem(32'd2, 32'hFFFFFFFD, 1'b0);
    push_exp(16'h0, 32'hFFFFFF6A);
    pulse_start(8'd1, 8'd0);
    wait_done(100);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: held level gives one run; edge while busy ignored; edge in DONE reruns
    fill_mem(32'd1, 32'd0, 1'b1);
    push_exp(16'h0, 32'd300);
    b0 = busy_cnt; w0 = wr_count;
    cfg_n_out = 8'd1; cfg_stride = 8'd1; start_reg = 1'b1;
    repeat (20) @(negedge clk);
    start_reg = 1'b0;
    repeat (2) @(negedge clk);
    pulse_start(8'd3, 8'd2);
    wait_done(100);
    repeat (5) @(negedge clk);
    check("t4_one_run_writes", 32'(wr_count - w0), 32'd1);
    check("t4_busy_cycles", 32'(busy_cnt - b0), 32'd27);
    push_exp(16'h0, 32'd300);
    w0 = wr_count;
    pulse_start(8'd1, 8'd1);
    check("t4_done_drop", {31'h0, done}, 32'h0);
    check("t4_busy_rerun", {31'h0, busy}, 32'h1);
    wait_done(100);
    check("t4_rerun_writes", 32'(wr_count - w0), 32'd1);

    // 5: reset during window 1 aborts the run
    push_exp(16'h0, 32'd300); push_exp(16'h4, 32'd325); push_exp(16'h8, 32'd350);
    w0 = wr_count;
    pulse_start(8'd3, 8'd1);
    cyc = 0;
    while ((wr_count == w0) && (cyc < 60)) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_first_write", 32'(wr_count - w0), 32'd1);
    repeat (3) @(negedge clk);
    check("t5_in_fetch", 32'(dbg_state), 32'(ST_FETCH));
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {31'h0, busy}, 32'h0);
    check("t5_rst_done", {31'h0, done}, 32'h0);
    check("t5_rst_status", status_o, 32'h0);
    check("t5_rst_we", {28'h0, o_we}, 32'h0);
    exp_q.delete();
    w0 = wr_count;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_no_writes", 32'(wr_count - w0), 32'd0);
    check("t5_done_low", {31'h0, done}, 32'h0);
    push_exp(16'h0, 32'd300); push_exp(16'h4, 32'd325);
    pulse_start(8'd2, 8'd1);
    wait_done(200);
    check("t5_rerun_writes", 32'(wr_count - w0), 32'd2);

    // 6: zero windows, then clr_done
    b0 = busy_cnt; w0 = wr_count;
    pulse_start(8'd0, 8'd1);
    check("t6_done", {31'h0, done}, 32'h1);
    check("t6_status", status_o, 32'hD00D1234);
    repeat (3) @(negedge clk);
    check("t6_no_writes", 32'(wr_count - w0), 32'd0);
    check("t6_no_busy", 32'(busy_cnt - b0), 32'd0);
    clr_done = 1'b1;
    @(negedge clk);
    clr_done = 1'b0;
    check("t6_clr_done", {31'h0, done}, 32'h0);
    check("t6_clr_status", status_o, 32'h0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
